// File: rtl/sda_kernel_ctrl_pkg.sv
// Shared definitions for the SDAccel kernel control/parameter register file.
// Holds the register map constants, status bit positions and the FSM encodings.
package sda_kernel_ctrl_pkg;

   localparam logic [31:0] CtrlOffset       = 32'h0000_0000;
   localparam int unsigned CtrlStartBit     = 0;
   localparam int unsigned CtrlDoneBit      = 1;
   localparam int unsigned CtrlIdleBit      = 2;
   localparam logic [31:0] DefaultParamBase = 32'h0000_0040;

   typedef enum logic [1:0] {
      StIdle,
      StGo,
      StRun
   } ctrl_state_e;

   typedef enum logic {
      PsAccept,
      PsReply
   } ps_state_e;

   // True when addr is a word-aligned byte address inside the parameter bank.
   function automatic logic param_hit(input logic [31:0] addr, input logic [31:0] base,
                                      input int unsigned words);
      logic [31:0] off;
      off = addr - base;
      return (addr >= base) && (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < words);
   endfunction

endpackage

// File: rtl/sda_param_server.sv
// Parameter server: accepts a byte address from the action, looks the word up in
// the register file through a combinational select port and replies with it.
module sda_param_server
   import sda_kernel_ctrl_pkg::*;
#(
   parameter int unsigned ParamWords = 8,
   parameter logic [31:0] ParamBase  = DefaultParamBase,
   parameter int unsigned IdxW       = 3
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            paramaddr_valid_i,
   input  logic [31:0]     paramaddr_i,
   output logic            paramaddr_stop_o,
   output logic            paramdata_valid_o,
   output logic [31:0]     paramdata_o,
   input  logic            paramdata_stop_i,
   output logic [IdxW-1:0] rf_idx_o,
   input  logic [31:0]     rf_data_i
);

   ps_state_e   state_q, state_d;
   logic [31:0] data_q, data_d;
   // Keeps the address channel stalled while reset is held.
   logic        en_q;

   assign rf_idx_o    = IdxW'((paramaddr_i - ParamBase) >> 2);
   assign paramdata_o = data_q;

   always_comb begin
      state_d           = state_q;
      data_d            = data_q;
      paramaddr_stop_o  = 1'b1;
      paramdata_valid_o = 1'b0;
      unique case (state_q)
         PsAccept: begin
            paramaddr_stop_o = ~en_q;
            if (en_q && paramaddr_valid_i) begin
               data_d  = param_hit(paramaddr_i, ParamBase, ParamWords) ? rf_data_i : 32'h0;
               state_d = PsReply;
            end
         end
         PsReply: begin
            paramdata_valid_o = 1'b1;
            if (!paramdata_stop_i) state_d = PsAccept;
         end
         default: state_d = PsAccept;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= PsAccept;
         data_q  <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         en_q    <= 1'b1;
      end
   end

endmodule

// File: rtl/sda_kernel_param_regfile.sv
// AXI4-Lite control slave with start/done/idle control word and a bank of
// 32-bit parameter words, driving the kernel go/done handshake.
module sda_kernel_param_regfile
   import sda_kernel_ctrl_pkg::*;
#(
   parameter int unsigned PARAM_WORDS = 8,
   parameter logic [31:0] PARAM_BASE  = DefaultParamBase
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] s_axi_awaddr,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic        go_0Ready,
   input  logic        go_0Stop,
   input  logic        done_0Ready,
   output logic        done_0Stop,
   input  logic        paramaddr_0Ready,
   input  logic [31:0] paramaddr_0Data,
   output logic        paramaddr_0Stop,
   output logic        paramdata_0Ready,
   output logic [31:0] paramdata_0Data,
   input  logic        paramdata_0Stop
);

   localparam int unsigned IdxW = (PARAM_WORDS > 1) ? $clog2(PARAM_WORDS) : 1;

   ctrl_state_e   state_q, state_d;
   logic          done_q, done_d;
   logic          awready_q, bvalid_q, arready_q, rvalid_q;
   logic [31:0]   rdata_q;
   logic [31:0]   params_q [PARAM_WORDS];

   logic          wr_fire, rd_fire, start_req, wr_param, done_evt;
   logic [IdxW-1:0] wr_idx, rd_idx, ps_idx;
   logic [31:0]   status, rd_word, ps_word;

   // The master holds address/data stable until the ready pulse, so the ready
   // cycle is the handshake cycle and the live bus values are used directly.
   assign wr_fire   = awready_q & s_axi_awvalid & s_axi_wvalid;
   assign rd_fire   = arready_q & s_axi_arvalid;
   assign wr_idx    = IdxW'((s_axi_awaddr - PARAM_BASE) >> 2);
   assign rd_idx    = IdxW'((s_axi_araddr - PARAM_BASE) >> 2);
   assign wr_param  = wr_fire & param_hit(s_axi_awaddr, PARAM_BASE, PARAM_WORDS);
   assign start_req = wr_fire & (s_axi_awaddr == CtrlOffset) & s_axi_wstrb[0]
                    & s_axi_wdata[CtrlStartBit];

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = awready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = 2'b00;

   always_comb begin
      status               = '0;
      status[CtrlStartBit] = (state_q != StIdle);
      status[CtrlDoneBit]  = done_q;
      status[CtrlIdleBit]  = (state_q == StIdle);
      rd_word              = '0;
      if (s_axi_araddr == CtrlOffset) begin
         rd_word = status;
      end else if (param_hit(s_axi_araddr, PARAM_BASE, PARAM_WORDS)) begin
         rd_word = params_q[rd_idx];
      end
   end

   always_comb begin
      state_d    = state_q;
      go_0Ready  = 1'b0;
      done_0Stop = 1'b1;
      done_evt   = 1'b0;
      unique case (state_q)
         StIdle: if (start_req) state_d = StGo;
         StGo: begin
            go_0Ready = 1'b1;
            if (!go_0Stop) state_d = StRun;
         end
         StRun: begin
            done_0Stop = 1'b0;
            if (done_0Ready) begin
               done_evt = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A done event landing on the read cycle wins, so it is seen by the next read.
   always_comb begin
      done_d = done_q;
      if (rd_fire && (s_axi_araddr == CtrlOffset) && done_q) done_d = 1'b0;
      if (done_evt) done_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         done_q    <= 1'b0;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         awready_q <= s_axi_awvalid & s_axi_wvalid & ~awready_q & ~bvalid_q;
         bvalid_q  <= wr_fire | (bvalid_q & ~s_axi_bready);
         arready_q <= s_axi_arvalid & ~arready_q & ~rvalid_q;
         rvalid_q  <= rd_fire | (rvalid_q & ~s_axi_rready);
         if (rd_fire) rdata_q <= rd_word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < PARAM_WORDS; k++) params_q[k] <= '0;
      end else if (wr_param) begin
         for (int b = 0; b < 4; b++) begin
            if (s_axi_wstrb[b]) params_q[wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
         end
      end
   end

   assign ps_word = (32'(ps_idx) < PARAM_WORDS) ? params_q[ps_idx] : 32'h0;

   sda_param_server #(
      .ParamWords (PARAM_WORDS),
      .ParamBase  (PARAM_BASE),
      .IdxW       (IdxW)
   ) u_param_server (
      .clk_i             (clk),
      .rst_ni            (reset),
      .paramaddr_valid_i (paramaddr_0Ready),
      .paramaddr_i       (paramaddr_0Data),
      .paramaddr_stop_o  (paramaddr_0Stop),
      .paramdata_valid_o (paramdata_0Ready),
      .paramdata_o       (paramdata_0Data),
      .paramdata_stop_i  (paramdata_0Stop),
      .rf_idx_o          (ps_idx),
      .rf_data_i         (ps_word)
   );

endmodule

// File: tb/tb_sda_kernel_param_regfile.sv
// Directed bench for sda_kernel_param_regfile: AXI-Lite register access, the
// go/done control sequence, the parameter server and reset during a run.
module tb_sda_kernel_param_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
   logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
   logic [3:0]  s_axi_wstrb;
   logic [1:0]  s_axi_bresp, s_axi_rresp;
   logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic        s_axi_rvalid, s_axi_rready;
   logic        go_0Ready, go_0Stop, done_0Ready, done_0Stop;
   logic        paramaddr_0Ready, paramaddr_0Stop, paramdata_0Ready, paramdata_0Stop;
   logic [31:0] paramaddr_0Data, paramdata_0Data;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   sda_kernel_param_regfile dut (
      .clk              (clk),
      .reset            (reset),
      .s_axi_awaddr     (s_axi_awaddr),
      .s_axi_awvalid    (s_axi_awvalid),
      .s_axi_awready    (s_axi_awready),
      .s_axi_wdata      (s_axi_wdata),
      .s_axi_wstrb      (s_axi_wstrb),
      .s_axi_wvalid     (s_axi_wvalid),
      .s_axi_wready     (s_axi_wready),
      .s_axi_bresp      (s_axi_bresp),
      .s_axi_bvalid     (s_axi_bvalid),
      .s_axi_bready     (s_axi_bready),
      .s_axi_araddr     (s_axi_araddr),
      .s_axi_arvalid    (s_axi_arvalid),
      .s_axi_arready    (s_axi_arready),
      .s_axi_rdata      (s_axi_rdata),
      .s_axi_rresp      (s_axi_rresp),
      .s_axi_rvalid     (s_axi_rvalid),
      .s_axi_rready     (s_axi_rready),
      .go_0Ready        (go_0Ready),
      .go_0Stop         (go_0Stop),
      .done_0Ready      (done_0Ready),
      .done_0Stop       (done_0Stop),
      .paramaddr_0Ready (paramaddr_0Ready),
      .paramaddr_0Data  (paramaddr_0Data),
      .paramaddr_0Stop  (paramaddr_0Stop),
      .paramdata_0Ready (paramdata_0Ready),
      .paramdata_0Data  (paramdata_0Data),
      .paramdata_0Stop  (paramdata_0Stop)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full write transaction; checks that a zero response arrived within the bound.
   task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
      int t;
      logic tmo;
      tmo = 1'b0;
      s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      t = 0;
      while (!(s_axi_awready && s_axi_wready) && t < 20) begin step(); t++; end
      if (t >= 20) tmo = 1'b1;
      step();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      t = 0;
      while (!s_axi_bvalid && t < 20) begin step(); t++; end
      if (t >= 20) tmo = 1'b1;
      chk(tag, {29'b0, tmo, s_axi_bresp}, 32'h0);
      s_axi_bready = 1'b1;
      step();
      s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
      int t;
      s_axi_araddr = a; s_axi_arvalid = 1'b1;
      t = 0;
      while (!s_axi_arready && t < 20) begin step(); t++; end
      step();
      s_axi_arvalid = 1'b0;
      t = 0;
      while (!s_axi_rvalid && t < 20) begin step(); t++; end
      d = (s_axi_rvalid && s_axi_rresp == 2'b00) ? s_axi_rdata : 32'hxxxx_xxxx;
      s_axi_rready = 1'b1;
      step();
      s_axi_rready = 1'b0;
   endtask

   // Unstalled parameter request; checks the reply and the return to accept.
   task automatic param_req(input string tag, input logic [31:0] a, input logic [31:0] exp);
      paramdata_0Stop = 1'b0;
      paramaddr_0Data = a; paramaddr_0Ready = 1'b1;
      step();
      paramaddr_0Ready = 1'b0;
      chk({tag, "_data"}, {paramdata_0Ready, paramdata_0Data[30:0]}, {1'b1, exp[30:0]});
      chk({tag, "_hi"}, {31'b0, paramdata_0Data[31]}, {31'b0, exp[31]});
      step();
      chk({tag, "_back"}, {30'b0, paramdata_0Ready, paramaddr_0Stop}, 32'h0);
   endtask

   initial begin
      reset = 1'b0;
      s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_araddr = '0;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
      s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      go_0Stop = 1'b0; done_0Ready = 1'b0;
      paramaddr_0Ready = 1'b0; paramaddr_0Data = '0; paramdata_0Stop = 1'b0;
      repeat (3) step();
      chk("rst_hs", {24'b0, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                     s_axi_rvalid, go_0Ready, done_0Stop, paramaddr_0Stop}, 32'h3);
      chk("rst_pd", {31'b0, paramdata_0Ready}, 32'h0);
      reset = 1'b1;
      repeat (2) step();
      chk("post_rst", {26'b0, s_axi_awready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                       go_0Ready, done_0Stop}, 32'h1);
      axi_read(32'h00, rd); chk("ctrl_reset", rd, 32'h4);

      // Byte-lane write and discarded write
      axi_write("wr_40", 32'h40, 32'hDEAD_BEEF, 4'b0011);
      axi_read(32'h40, rd); chk("rd_40", rd, 32'h0000_BEEF);
      axi_write("wr_20", 32'h20, 32'hCAFE_F00D, 4'b1111);
      axi_read(32'h20, rd); chk("rd_20", rd, 32'h0);
      axi_write("wr_44", 32'h44, 32'h1234_5678, 4'b1111);
      axi_write("wr_48", 32'h48, 32'h0000_0100, 4'b1111);
      axi_read(32'h48, rd); chk("rd_48", rd, 32'h100);

      // Start with go held off for three cycles
      go_0Stop = 1'b1;
      axi_write("wr_start", 32'h00, 32'h1, 4'b0001);
      for (int i = 0; i < 3; i++) begin
         chk("go_held", {31'b0, go_0Ready}, 32'h1);
         step();
      end
      go_0Stop = 1'b0;
      step();
      chk("run", {30'b0, go_0Ready, done_0Stop}, 32'h0);
      axi_read(32'h00, rd); chk("ctrl_run", rd, 32'h1);
      done_0Ready = 1'b1;
      step();
      done_0Ready = 1'b0;
      chk("idle_stop", {31'b0, done_0Stop}, 32'h1);
      axi_read(32'h00, rd); chk("ctrl_done", rd, 32'h6);
      axi_read(32'h00, rd); chk("ctrl_cor", rd, 32'h4);

      // Parameter server with a stalled first reply
      chk("ps_accept", {31'b0, paramaddr_0Stop}, 32'h0);
      paramdata_0Stop = 1'b1;
      paramaddr_0Data = 32'h44; paramaddr_0Ready = 1'b1;
      step();
      paramaddr_0Ready = 1'b0;
      chk("ps44_data", paramdata_0Data, 32'h1234_5678);
      chk("ps44_hs", {30'b0, paramdata_0Ready, paramaddr_0Stop}, 32'h3);
      step(); step();
      chk("ps44_stall", {31'b0, paramdata_0Ready}, 32'h1);
      paramdata_0Stop = 1'b0;
      step();
      chk("ps44_rel", {31'b0, paramdata_0Ready}, 32'h0);
      param_req("ps48", 32'h48, 32'h100);
      param_req("ps60", 32'h60, 32'h0);
      param_req("ps42", 32'h42, 32'h0);
      param_req("ps3c", 32'h3C, 32'h0);

      // Reset in the middle of a run with a reply pending
      axi_write("wr_start2", 32'h00, 32'h1, 4'b0001);
      step();
      chk("run2", {31'b0, done_0Stop}, 32'h0);
      paramdata_0Stop = 1'b1;
      paramaddr_0Data = 32'h44; paramaddr_0Ready = 1'b1;
      step();
      paramaddr_0Ready = 1'b0;
      chk("pd_pending", {31'b0, paramdata_0Ready}, 32'h1);
      reset = 1'b0;
      #1;
      chk("abort", {28'b0, paramdata_0Ready, go_0Ready, done_0Stop, paramaddr_0Stop},
          32'h3);
      paramdata_0Stop = 1'b0;
      step();
      reset = 1'b1;
      repeat (2) step();
      axi_read(32'h00, rd); chk("ctrl_abort", rd, 32'h4);
      axi_read(32'h44, rd); chk("rd_44_rst", rd, 32'h0);
      axi_write("wr_start3", 32'h00, 32'h1, 4'b0001);
      step();
      chk("run3", {30'b0, go_0Ready, done_0Stop}, 32'h0);
      done_0Ready = 1'b1;
      step();
      done_0Ready = 1'b0;
      axi_read(32'h00, rd); chk("ctrl_done3", rd, 32'h6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
